// File: rtl/matrix_key_scan_pkg.sv
// Shared constants, key codes and map helpers for the 4x4 key matrix scanner.
package key_pkg;
  localparam int KEY_ROWS   = 4;
  localparam int KEY_COLS   = 4;
  localparam int KEY_CODE_W = 4;
  localparam int KEY_BITS   = KEY_ROWS * KEY_COLS;

  localparam logic [KEY_CODE_W-1:0] KEY_UP    = 4'd1;
  localparam logic [KEY_CODE_W-1:0] KEY_LEFT  = 4'd4;
  localparam logic [KEY_CODE_W-1:0] KEY_OK    = 4'd5;
  localparam logic [KEY_CODE_W-1:0] KEY_RIGHT = 4'd6;
  localparam logic [KEY_CODE_W-1:0] KEY_DOWN  = 4'd9;
  localparam logic [KEY_CODE_W-1:0] KEY_RST   = 4'd15;

  typedef logic [KEY_BITS-1:0] key_map_t;
  typedef enum logic [1:0] {MAP_NONE, MAP_ONE, MAP_MULTI} map_kind_t;

  function automatic map_kind_t map_kind(input key_map_t m);
    int n;
    n = 0;
    for (int i = 0; i < KEY_BITS; i++) n += int'(m[i]);
    return (n == 0) ? MAP_NONE : (n == 1) ? MAP_ONE : MAP_MULTI;
  endfunction

  // Lowest set bit; only meaningful when exactly one bit is set.
  function automatic logic [KEY_CODE_W-1:0] key_index(input key_map_t m);
    logic [KEY_CODE_W-1:0] idx;
    idx = '0;
    for (int i = KEY_BITS - 1; i >= 0; i--) if (m[i]) idx = KEY_CODE_W'(i);
    return idx;
  endfunction
endpackage

// File: rtl/matrix_key_scan_if.sv
// Matrix pins plus the decoded key event outputs.
interface matrix_key_scan_if;
  import key_pkg::*;
  logic [KEY_COLS-1:0]   key_col;
  logic [KEY_ROWS-1:0]   key_row;
  logic [KEY_CODE_W-1:0] key_code;
  logic                  key_valid;
  logic                  key_release;
  logic                  key_held;

  modport master (input key_col, output key_row, key_code, key_valid, key_release, key_held);
  modport slave  (output key_col, input key_row, key_code, key_valid, key_release, key_held);
endinterface

// File: rtl/key_frame_debounce.sv
// Accepts a 16-bit scan frame only after DEB_FRAMES identical consecutive frames.
module key_frame_debounce
  import key_pkg::*;
#(
  parameter int DEB_FRAMES = 3
) (
  input  logic     clk,
  input  logic     rst,
  input  key_map_t i_frame,
  input  logic     i_frame_stb,
  output key_map_t o_stable,
  output logic     o_change
);
  localparam int CW = $clog2(DEB_FRAMES + 1);

  key_map_t        r_prev, r_stable;
  logic [CW-1:0]   r_cnt;
  logic            r_change;
  logic [CW-1:0]   w_cnt_nxt;

  always_comb begin
    w_cnt_nxt = CW'(1);
    if (i_frame == r_prev)
      w_cnt_nxt = (r_cnt == CW'(DEB_FRAMES)) ? r_cnt : r_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev   <= '0;
      r_stable <= '0;
      r_cnt    <= '0;
      r_change <= 1'b0;
    end else begin
      r_change <= 1'b0;
      if (i_frame_stb) begin
        r_prev <= i_frame;
        r_cnt  <= w_cnt_nxt;
        if (w_cnt_nxt == CW'(DEB_FRAMES) && i_frame != r_stable) begin
          r_stable <= i_frame;
          r_change <= 1'b1;
        end
      end
    end
  end

  assign o_stable = r_stable;
  assign o_change = r_change;
endmodule

// File: rtl/matrix_key_scan.sv
// 4x4 key matrix scanner: row drive, column sampling, frame debounce, press/release decode.
module matrix_key_scan
  import key_pkg::*;
#(
  parameter int CLK_DIV    = 10000,
  parameter int DEB_FRAMES = 3
) (
  input  logic               clk,
  input  logic               rst,
  matrix_key_scan_if.master  bus
);
  localparam int DW = $clog2(CLK_DIV);

  logic [DW-1:0]         r_div;
  logic [1:0]            r_row_idx;
  logic [KEY_ROWS-1:0]   r_key_row;
  key_map_t              r_frame;
  key_map_t              w_frame_nxt, w_stable;
  logic                  w_slot_end, w_frame_stb, w_change;

  assign w_slot_end  = (r_div == DW'(CLK_DIV - 1));
  assign w_frame_stb = w_slot_end && (r_row_idx == 2'd3);

  always_comb begin
    w_frame_nxt = r_frame;
    w_frame_nxt[{r_row_idx, 2'b00} +: KEY_COLS] = ~bus.key_col;
  end

  // key_row follows the row index one cycle late, so a row is driven for a
  // full slot ending on its sample cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div     <= '0;
      r_row_idx <= 2'd0;
      r_key_row <= 4'b1110;
      r_frame   <= '0;
    end else begin
      r_key_row <= ~(4'b0001 << r_row_idx);
      if (w_slot_end) begin
        r_div     <= '0;
        r_row_idx <= r_row_idx + 2'd1;
        r_frame   <= w_frame_nxt;
      end else begin
        r_div <= r_div + 1'b1;
      end
    end
  end

  key_frame_debounce #(.DEB_FRAMES(DEB_FRAMES)) u_deb (
    .clk        (clk),
    .rst        (rst),
    .i_frame    (w_frame_nxt),
    .i_frame_stb(w_frame_stb),
    .o_stable   (w_stable),
    .o_change   (w_change)
  );

  key_map_t              r_last_map;
  logic [KEY_CODE_W-1:0] r_code, r_pend_code;
  logic                  r_valid, r_release, r_held, r_pend;

  // A press is reported only while r_held tracks an accepted single key or the
  // map came from empty; a single left over from a multi-press stays silent.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_map  <= '0;
      r_code      <= '0;
      r_pend_code <= '0;
      r_valid     <= 1'b0;
      r_release   <= 1'b0;
      r_held      <= 1'b0;
      r_pend      <= 1'b0;
    end else begin
      r_valid   <= 1'b0;
      r_release <= 1'b0;
      if (r_pend) begin
        r_pend  <= 1'b0;
        r_valid <= 1'b1;
        r_code  <= r_pend_code;
        r_held  <= 1'b1;
      end
      if (w_change) begin
        r_last_map <= w_stable;
        if (map_kind(w_stable) == MAP_ONE) begin
          if (map_kind(r_last_map) == MAP_NONE) begin
            r_valid <= 1'b1;
            r_code  <= key_index(w_stable);
            r_held  <= 1'b1;
          end else if (r_held) begin
            r_release   <= 1'b1;
            r_held      <= 1'b0;
            r_pend      <= 1'b1;
            r_pend_code <= key_index(w_stable);
          end
        end else begin
          r_held <= 1'b0;
          if (r_held) r_release <= 1'b1;
        end
      end
    end
  end

  assign bus.key_row     = r_key_row;
  assign bus.key_code    = r_code;
  assign bus.key_valid   = r_valid;
  assign bus.key_release = r_release;
  assign bus.key_held    = r_held;
endmodule

// File: tb/tb_matrix_key_scan.sv
// Scoreboard bench for matrix_key_scan: a key-matrix model drives key_col from key_row.
module tb_matrix_key_scan;
  import key_pkg::*;

  localparam int CLK_DIV    = 4;
  localparam int DEB_FRAMES = 2;
  localparam int FRAME      = 4 * CLK_DIV;

  typedef struct {
    logic       rel;
    logic [3:0] code;
    logic       adj;
  } ev_t;

  logic     clk = 1'b0;
  logic     rst = 1'b1;
  key_map_t keys = '0;
  int       errors = 0, checks = 0;
  int       cyc = 0, rel_cyc = -100, valid_cyc = -100;
  ev_t      exp_q[$];

  matrix_key_scan_if kif();

  matrix_key_scan #(.CLK_DIV(CLK_DIV), .DEB_FRAMES(DEB_FRAMES)) dut (
    .clk(clk),
    .rst(rst),
    .bus(kif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Membrane matrix: a pressed key pulls its column low while its row is driven low.
  always_comb begin
    kif.key_col = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!kif.key_row[r] && keys[r*4+c]) kif.key_col[c] = 1'b0;
  end

  task automatic expect_ev(input logic rel, input logic [3:0] code, input logic adj);
    ev_t e;
    e.rel = rel; e.code = code; e.adj = adj;
    exp_q.push_back(e);
  endtask

  task automatic monitor();
    ev_t e;
    forever begin
      @(negedge clk);
      if (!rst && (kif.key_valid || kif.key_release)) begin
        checks++;
        if (kif.key_valid && kif.key_release) begin
          errors++;
          $display("FAIL both_high: valid=1 release=1 at cycle %0d, required never both", cyc);
        end else if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: valid=%0b release=%0b code=%0d at cycle %0d, required none",
                   kif.key_valid, kif.key_release, kif.key_code, cyc);
        end else begin
          e = exp_q.pop_front();
          if (kif.key_release !== e.rel || kif.key_code !== e.code) begin
            errors++;
            $display("FAIL event: release=%0b code=%0d, required release=%0b code=%0d",
                     kif.key_release, kif.key_code, e.rel, e.code);
          end
          if (e.adj) begin
            checks++;
            if (cyc != rel_cyc + 1) begin
              errors++;
              $display("FAIL valid_after_release: valid at cycle %0d, required %0d", cyc, rel_cyc + 1);
            end
          end
        end
        if (kif.key_release) rel_cyc = cyc;
        if (kif.key_valid) valid_cyc = cyc;
      end
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d events pending after %0d cycles, required 0", exp_q.size(), n);
      exp_q.delete();
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [3:0] one, exp_row;
    one = 4'b0001;
    rst = 1'b1;
    keys = '0;
    idle(3);
    checks += 5;
    if (kif.key_row !== 4'b1110) begin errors++; $display("FAIL reset_row: got %b, required 1110", kif.key_row); end
    if (kif.key_code !== 4'd0) begin errors++; $display("FAIL reset_code: got %0d, required 0", kif.key_code); end
    if (kif.key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", kif.key_valid); end
    if (kif.key_release !== 1'b0) begin errors++; $display("FAIL reset_release: got %b, required 0", kif.key_release); end
    if (kif.key_held !== 1'b0) begin errors++; $display("FAIL reset_held: got %b, required 0", kif.key_held); end
    rst = 1'b0;
    for (int k = 1; k <= 10 * FRAME; k++) begin
      @(negedge clk);
      exp_row = ~(one << (((k - 1) / CLK_DIV) % 4));
      checks += 2;
      if (kif.key_row !== exp_row) begin
        errors++;
        $display("FAIL idle_row: cycle %0d got %b, required %b", k, kif.key_row, exp_row);
      end
      if (kif.key_held !== 1'b0) begin
        errors++;
        $display("FAIL idle_held: cycle %0d got %b, required 0", k, kif.key_held);
      end
    end
  endtask

  task automatic test_single_press();
    int t0;
    keys = '0;
    keys[9] = 1'b1;
    t0 = cyc;
    expect_ev(1'b0, 4'd9, 1'b0);
    drain(4 * FRAME);
    checks++;
    if (valid_cyc < t0 || valid_cyc - t0 > 3 * FRAME + 2) begin
      errors++;
      $display("FAIL press_latency: %0d cycles, required <= %0d", valid_cyc - t0, 3 * FRAME + 2);
    end
    idle(3 * FRAME);
    checks++;
    if (kif.key_held !== 1'b1) begin errors++; $display("FAIL press_held: got %b, required 1", kif.key_held); end
    keys = '0;
    expect_ev(1'b1, 4'd9, 1'b0);
    drain(4 * FRAME);
    idle(2);
    checks += 2;
    if (kif.key_held !== 1'b0) begin errors++; $display("FAIL release_held: got %b, required 0", kif.key_held); end
    if (kif.key_code !== 4'd9) begin errors++; $display("FAIL release_code: got %0d, required 9", kif.key_code); end
    idle(3 * FRAME);
  endtask

  task automatic test_bounce();
    int n;
    n = 0;
    while (kif.key_row !== 4'b0111 && n < 64) begin @(negedge clk); n++; end
    while (kif.key_row !== 4'b1110 && n < 64) begin @(negedge clk); n++; end
    checks++;
    if (n >= 64) begin errors++; $display("FAIL bounce_sync: waited %0d cycles, required < 64", n); end
    // Toggle phase chosen so consecutive row-0 samples disagree during the bounce.
    for (int j = 0; j < 2 * FRAME; j++) begin
      keys[3] = (((j + 1) / 3) % 2) == 1;
      @(negedge clk);
    end
    keys[3] = 1'b1;
    expect_ev(1'b0, 4'd3, 1'b0);
    drain(4 * FRAME);
    checks++;
    if (kif.key_code !== 4'd3) begin errors++; $display("FAIL bounce_code: got %0d, required 3", kif.key_code); end
    keys = '0;
    expect_ev(1'b1, 4'd3, 1'b0);
    drain(4 * FRAME);
    idle(3 * FRAME);
  endtask

  task automatic test_two_keys();
    keys = '0;
    keys[1] = 1'b1;
    keys[6] = 1'b1;
    idle(5 * FRAME);
    checks++;
    if (kif.key_held !== 1'b0) begin errors++; $display("FAIL multi_held: got %b, required 0", kif.key_held); end
    keys[6] = 1'b0;
    idle(5 * FRAME);
    checks++;
    if (kif.key_held !== 1'b0) begin errors++; $display("FAIL leftover_held: got %b, required 0", kif.key_held); end
    keys = '0;
    idle(4 * FRAME);
    keys[6] = 1'b1;
    expect_ev(1'b0, 4'd6, 1'b0);
    drain(4 * FRAME);
    checks++;
    if (kif.key_held !== 1'b1) begin errors++; $display("FAIL after_multi_held: got %b, required 1", kif.key_held); end
    keys = '0;
    expect_ev(1'b1, 4'd6, 1'b0);
    drain(4 * FRAME);
    idle(3 * FRAME);
  endtask

  task automatic test_reset_mid();
    keys = '0;
    keys[5] = 1'b1;
    expect_ev(1'b0, 4'd5, 1'b0);
    drain(4 * FRAME);
    idle(FRAME + 5);
    rst = 1'b1;
    @(negedge clk);
    checks += 5;
    if (kif.key_row !== 4'b1110) begin errors++; $display("FAIL midrst_row: got %b, required 1110", kif.key_row); end
    if (kif.key_code !== 4'd0) begin errors++; $display("FAIL midrst_code: got %0d, required 0", kif.key_code); end
    if (kif.key_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b, required 0", kif.key_valid); end
    if (kif.key_release !== 1'b0) begin errors++; $display("FAIL midrst_release: got %b, required 0", kif.key_release); end
    if (kif.key_held !== 1'b0) begin errors++; $display("FAIL midrst_held: got %b, required 0", kif.key_held); end
    rst = 1'b0;
    expect_ev(1'b0, 4'd5, 1'b0);
    drain(4 * FRAME);
    checks++;
    if (kif.key_held !== 1'b1) begin errors++; $display("FAIL midrst_reheld: got %b, required 1", kif.key_held); end
    keys = '0;
    expect_ev(1'b1, 4'd5, 1'b0);
    drain(4 * FRAME);
    idle(3 * FRAME);
  endtask

  task automatic test_back_to_back();
    keys = '0;
    keys[0] = 1'b1;
    expect_ev(1'b0, 4'd0, 1'b0);
    drain(4 * FRAME);
    idle(FRAME);
    keys = '0;
    keys[15] = 1'b1;
    expect_ev(1'b1, 4'd0, 1'b0);
    expect_ev(1'b0, 4'd15, 1'b1);
    drain(5 * FRAME);
    checks++;
    if (kif.key_held !== 1'b1) begin errors++; $display("FAIL switch_held: got %b, required 1", kif.key_held); end
    keys = '0;
    expect_ev(1'b1, 4'd15, 1'b0);
    drain(4 * FRAME);
    idle(3 * FRAME);
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_single_press();
    test_bounce();
    test_two_keys();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/matrix_key_scan.md
Name: matrix_key_scan

Overview:
- Reads a 4x4 membrane key matrix. Drives one row low at a time and samples the column lines.
- Debounces whole scan frames, then emits a 4-bit key code with a one-cycle valid pulse on press and a release pulse.
- Mirror of the LED-matrix row/column driver: this block drives rows and reads columns back.
- Sits beside the single-key debouncers. Feeds the test state logic as an alternative input for vision-test answers and menu entry.

Parameters:
- CLK_DIV, 10000: clock cycles per row slot (1 ms at 10 MHz). Must be >= 2.
- DEB_FRAMES, 3: number of consecutive identical frames required before a pattern is accepted. Must be >= 1.

Ports:
- clk  in  1  system clock (10 MHz)
- rst  in  1  synchronous reset, active-high
- key_col  in  4  column sense lines, active-low, externally pulled up
- key_row  out  4  row drive, active-low, exactly one bit low at a time
- key_code  out  4  code of the last accepted key = row*4 + col
- key_valid  out  1  one-cycle pulse when a single key press is accepted
- key_release  out  1  one-cycle pulse when that key is released
- key_held  out  1  high while the accepted single key remains stably pressed

Behaviour:
- Reset: sync, active-high. Clears every register, including after reset is applied mid-frame.
  - key_row=4'b1110, row index=0, divider=0
  - frame/stable maps=0, stable count=0
  - key_code=0, key_valid=0, key_release=0, key_held=0
- Row scan: divider counts 0..CLK_DIV-1. On divider==CLK_DIV-1:
  - key_col is sampled into frame bits [row*4 +: 4], inverted so 1 = pressed.
  - row index advances 0→1→2→3→0 (wrap).
  - key_row rotates on the next cycle.
  - Sampling on the last slot cycle gives CLK_DIV-1 cycles of settling.
- Frame complete: asserted when row 3 is sampled. One frame = 4*CLK_DIV cycles.
- Frame debounce, at each frame complete:
  - new frame == previous frame: stable count increments, saturating at DEB_FRAMES.
  - otherwise: count resets to 1 and previous frame is updated.
  - count reaches DEB_FRAMES and new frame != stable map: stable map := frame, and the map change is flagged.
- Press/release decode, on a stable map change, evaluated the cycle after the update:
  - 0 bits → exactly 1 bit set: key_code := bit index, key_valid=1 for one cycle, key_held=1.
  - single bit → 0 bits: key_release=1 for one cycle, key_held=0. key_code holds its last value.
  - any transition into 2 or more bits set (ghosting or multi-press): no valid pulse. key_held=0. If it came from a single bit, key_release pulses.
  - multiple bits → single bit: no valid pulse. All keys must return to zero before the next press is accepted.
  - single → different single within one accepted change: key_release pulses then key_valid pulses. Release in cycle N, valid plus new code in cycle N+1.
- Latency: key_valid rises 1 cycle after the frame complete that accepts the pattern. Worst case from a clean press is (DEB_FRAMES+1)*4*CLK_DIV + 2 cycles.
- key_valid and key_release are never high in the same cycle.
- Bounce shorter than one frame is never reported.

Decomposition:
- Shared package `key_pkg`:
  - constants KEY_ROWS=4, KEY_COLS=4, KEY_CODE_W=4
  - named key codes, e.g. KEY_UP=4'd1, KEY_LEFT=4'd4, KEY_RIGHT=4'd6, KEY_DOWN=4'd9, KEY_OK=4'd5, KEY_RST=4'd15
- One sub-module, `key_frame_debounce`:
  - 16-bit frame in, frame strobe in, stable map out, change flag out.
  - Parameterised by DEB_FRAMES.
- Row scan divider and press decode stay in the top of the block.

Test Plan (sim with CLK_DIV=4, DEB_FRAMES=2):
1. Reset then idle with key_col=4'hF:
   - key_row cycles 1110,1101,1011,0111, each held 4 cycles, wrapping.
   - All outputs stay 0 for 10 frames.
2. Model key row2/col1 pressed solidly:
   - key_valid pulses exactly once with key_code=9.
   - Pulse occurs ≤ 3 frames + 2 cycles after the press.
   - key_held=1 until release; on release, key_release pulses once and key_code stays 9.
3. Bounce: row0/col3 toggled every 3 cycles for 2 frames, then held:
   - No pulse during the bounce.
   - Exactly one key_valid with code=3 after 2 stable frames.
4. Two keys (codes 1 and 6) pressed together:
   - No key_valid, key_held=0.
   - Release 6 only: still no valid.
   - Release all, then press 6: key_valid with code=6.
5. Assert rst mid-frame while key 5 is held:
   - Next cycle key_row=1110 and all outputs 0.
   - After reset, key_valid code=5 re-reported after DEB_FRAMES frames.
6. Press 0, then switch directly to 15 within one frame:
   - key_release pulses, then the next cycle key_valid with code=15.
   - Never both high in the same cycle.
